// File: rtl/mem_responder_if.sv
// Memory-port bundle between a controller (master) and the responder (slave).
// MEM_RESP_PARITY_EN adds the inject_par / parity_err pair.
interface mem_responder_if #(
    parameter int WIDTH   = 32,
    parameter int ADWIDTH = 16
);
    logic               rd_en;
    logic               wr_en;
    logic [ADWIDTH-1:0] addr;
    logic [WIDTH-1:0]   wr_data;
    logic [WIDTH-1:0]   rd_data;
    logic               ack;
    logic               busy;
    logic               err;
`ifdef MEM_RESP_PARITY_EN
    logic               inject_par;
    logic               parity_err;

    modport master (output rd_en, wr_en, addr, wr_data, inject_par,
                    input  rd_data, ack, busy, err, parity_err);
    modport slave  (input  rd_en, wr_en, addr, wr_data, inject_par,
                    output rd_data, ack, busy, err, parity_err);
`else
    modport master (output rd_en, wr_en, addr, wr_data,
                    input  rd_data, ack, busy, err);
    modport slave  (input  rd_en, wr_en, addr, wr_data,
                    output rd_data, ack, busy, err);
`endif
endinterface

// File: rtl/mem_responder.sv
// Edge-triggered word RAM responder with programmable latency and a one-cycle ack.
// Optional per-word even parity when MEM_RESP_PARITY_EN is defined.
module mem_responder #(
    parameter int WIDTH      = 32,
    parameter int ADWIDTH    = 16,
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic       clk,
    input  logic       reset,
    mem_responder_if.slave bus,
    output logic [1:0] o_dbg_state
);
    // Handshake: a request is the rising edge of rd_en or wr_en while idle;
    // ack pulses for one cycle exactly LATENCY edges after the accepting edge.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    localparam int         DEPTH    = 2 ** DEPTH_LOG2;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t               r_state;
    state_t               w_next_state;
    logic                 r_rd_en_q;
    logic                 r_wr_en_q;
    logic [3:0]           r_cnt;
    logic                 r_op_wr;
    logic [ADWIDTH-1:0]   r_addr;
    logic [WIDTH-1:0]     r_wdata;
    logic [WIDTH-1:0]     r_rd_data;
    logic                 r_err;
    logic [WIDTH-1:0]     r_mem [DEPTH];

    logic                 w_rise_rd;
    logic                 w_rise_wr;
    logic                 w_accept;
    logic                 w_conflict;
    logic                 w_access;
    logic                 w_in_range;
    logic [DEPTH_LOG2-1:0] w_idx;

    assign w_rise_rd  = bus.rd_en & ~r_rd_en_q;
    assign w_rise_wr  = bus.wr_en & ~r_wr_en_q;
    assign w_in_range = ((r_addr >> DEPTH_LOG2) == '0);
    assign w_idx      = r_addr[DEPTH_LOG2-1:0];

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_conflict   = 1'b0;
        w_access     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rise_rd && w_rise_wr) begin
                    w_conflict = 1'b1;
                end else if (w_rise_rd || w_rise_wr) begin
                    w_accept     = 1'b1;
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_access     = 1'b1;
                    w_next_state = S_ACK;
                end
            end
            S_ACK:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Storage has no reset; a write still pending when reset hits is dropped.
    always_ff @(posedge clk) begin
        if (w_access && r_op_wr && w_in_range && !reset)
            r_mem[w_idx] <= r_wdata;
    end

`ifdef MEM_RESP_PARITY_EN
    logic r_inj;
    logic r_perr;
    logic r_par [DEPTH];

    always_ff @(posedge clk) begin
        if (w_access && r_op_wr && w_in_range && !reset)
            r_par[w_idx] <= (^r_wdata) ^ r_inj;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_inj  <= 1'b0;
            r_perr <= 1'b0;
        end else begin
            r_perr <= 1'b0;
            if (w_accept)
                r_inj <= bus.inject_par;
            if (w_access && !r_op_wr && w_in_range)
                r_perr <= (^r_mem[w_idx]) ^ r_par[w_idx];
        end
    end

    assign bus.parity_err = r_perr;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_en_q <= 1'b0;
            r_wr_en_q <= 1'b0;
            r_cnt     <= 4'd0;
            r_op_wr   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rd_data <= '0;
            r_err     <= 1'b0;
        end else begin
            r_rd_en_q <= bus.rd_en;
            r_wr_en_q <= bus.wr_en;
            r_err     <= 1'b0;
            if (w_accept) begin
                r_op_wr <= w_rise_wr;
                r_addr  <= bus.addr;
                r_wdata <= bus.wr_data;
                r_cnt   <= CNT_INIT;
            end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_conflict)
                r_err <= 1'b1;
            if (w_access) begin
                if (!w_in_range) begin
                    r_err <= 1'b1;
                    if (!r_op_wr) r_rd_data <= '0;
                end else if (!r_op_wr) begin
                    r_rd_data <= r_mem[w_idx];
                end
            end
        end
    end

    assign bus.rd_data  = r_rd_data;
    assign bus.ack      = (r_state == S_ACK);
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.err      = r_err;
    assign o_dbg_state  = r_state;
endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (LATENCY=2, DEPTH_LOG2=8).
// Define MEM_RESP_PARITY_EN to also exercise the parity feature.
module tb_mem_responder;
    logic       clk;
    logic       reset;
    logic [1:0] dbg_state;
    int         n_cmp = 0;
    int         n_bad = 0;

    mem_responder_if #(.WIDTH(32), .ADWIDTH(16)) bus ();

    mem_responder #(.WIDTH(32), .ADWIDTH(16), .DEPTH_LOG2(8), .LATENCY(2)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.slave),
        .o_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One complete access; lat = edges from accept to ack, -1 if no ack seen.
    task automatic access(input logic wr, input logic [15:0] a, input logic [31:0] d,
                          input logic inj, output int lat, output logic busy1,
                          output logic e, output logic pe, output logic ack2,
                          output logic [31:0] rd);
        lat = -1; busy1 = 1'b0; e = 1'b0; pe = 1'b0; ack2 = 1'b0; rd = '0;
        @(negedge clk);
        bus.addr    = a;
        bus.wr_data = d;
`ifdef MEM_RESP_PARITY_EN
        bus.inject_par = inj;
`else
        pe = pe & inj;
`endif
        if (wr) bus.wr_en = 1'b1;
        else    bus.rd_en = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) busy1 = bus.busy;
            if (bus.ack === 1'b1) begin
                lat = k - 1;
                e   = bus.err;
                rd  = bus.rd_data;
`ifdef MEM_RESP_PARITY_EN
                pe  = bus.parity_err;
`endif
                break;
            end
        end
        bus.rd_en = 1'b0;
        bus.wr_en = 1'b0;
        @(negedge clk);
        ack2 = bus.ack;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.addr = '0; bus.wr_data = '0;
`ifdef MEM_RESP_PARITY_EN
        bus.inject_par = 1'b0;
`endif
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b want 0", bus.ack); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", bus.err); end
        n_cmp++; if (bus.rd_data !== 32'h0) begin n_bad++; $display("FAIL reset_rd_data: got %h want 0", bus.rd_data); end
        n_cmp++; if (dbg_state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
`ifdef MEM_RESP_PARITY_EN
        n_cmp++; if (bus.parity_err !== 1'b0) begin n_bad++; $display("FAIL reset_parity_err: got %b want 0", bus.parity_err); end
`endif
    endtask

    task automatic test_write_read();
        int lat; logic b1, e, pe, a2; logic [31:0] rd;
        access(1'b1, 16'h0010, 32'hDEADBEEF, 1'b0, lat, b1, e, pe, a2, rd);
        n_cmp++; if (b1 !== 1'b1) begin n_bad++; $display("FAIL wr_busy: got %b want 1", b1); end
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL wr_latency: got %0d want 2", lat); end
        n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL wr_err: got %b want 0", e); end
        n_cmp++; if (a2 !== 1'b0) begin n_bad++; $display("FAIL wr_ack_width: got %b want 0", a2); end
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL wr_rd_data_kept: got %h want 0", rd); end
        access(1'b0, 16'h0010, 32'h0, 1'b0, lat, b1, e, pe, a2, rd);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL rd_latency: got %0d want 2", lat); end
        n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_data: got %h want deadbeef", rd); end
        n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL rd_err: got %b want 0", e); end
    endtask

    task automatic test_held_enable();
        int acks;
        @(negedge clk);
        bus.addr = 16'h0010; bus.rd_en = 1'b1; acks = 0;
        repeat (6) begin @(negedge clk); acks += int'(bus.ack); end
        bus.rd_en = 1'b0;
        repeat (3) begin @(negedge clk); acks += int'(bus.ack); end
        n_cmp++; if (acks !== 1) begin n_bad++; $display("FAIL held_one_ack: got %0d want 1", acks); end
        bus.rd_en = 1'b1; acks = 0;
        repeat (6) begin @(negedge clk); acks += int'(bus.ack); end
        bus.rd_en = 1'b0;
        repeat (2) begin @(negedge clk); acks += int'(bus.ack); end
        n_cmp++; if (acks !== 1) begin n_bad++; $display("FAIL reraise_one_ack: got %0d want 1", acks); end
        n_cmp++; if (bus.rd_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL held_rd_data: got %h want deadbeef", bus.rd_data); end
    endtask

    task automatic test_conflict();
        int lat; logic b1, e, pe, a2; logic [31:0] rd;
        @(negedge clk);
        bus.addr = 16'h0010; bus.wr_data = 32'h0; bus.rd_en = 1'b1; bus.wr_en = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL conflict_err: got %b want 1", bus.err); end
        n_cmp++; if (bus.ack !== 1'b0) begin n_bad++; $display("FAIL conflict_ack: got %b want 0", bus.ack); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL conflict_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.rd_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL conflict_rd_data: got %h want deadbeef", bus.rd_data); end
        @(negedge clk);
        n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL conflict_err_width: got %b want 0", bus.err); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL conflict_held_busy: got %b want 0", bus.busy); end
        bus.rd_en = 1'b0; bus.wr_en = 1'b0;
        @(negedge clk);
        access(1'b0, 16'h0010, 32'h0, 1'b0, lat, b1, e, pe, a2, rd);
        n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL conflict_no_write: got %h want deadbeef", rd); end
    endtask

    task automatic test_out_of_range();
        int lat; logic b1, e, pe, a2; logic [31:0] rd;
        access(1'b1, 16'h0000, 32'hCAFEF00D, 1'b0, lat, b1, e, pe, a2, rd);
        access(1'b0, 16'h0100, 32'h0, 1'b0, lat, b1, e, pe, a2, rd);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL oor_rd_latency: got %0d want 2", lat); end
        n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL oor_rd_err: got %b want 1", e); end
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL oor_rd_data: got %h want 0", rd); end
`ifdef MEM_RESP_PARITY_EN
        n_cmp++; if (pe !== 1'b0) begin n_bad++; $display("FAIL oor_parity_err: got %b want 0", pe); end
`endif
        access(1'b1, 16'h0100, 32'h00001234, 1'b0, lat, b1, e, pe, a2, rd);
        n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL oor_wr_err: got %b want 1", e); end
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL oor_wr_latency: got %0d want 2", lat); end
        access(1'b0, 16'h0000, 32'h0, 1'b0, lat, b1, e, pe, a2, rd);
        n_cmp++; if (rd !== 32'hCAFEF00D) begin n_bad++; $display("FAIL oor_no_alias: got %h want cafef00d", rd); end
        n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL inrange_err: got %b want 0", e); end
    endtask

    task automatic test_reset_abort();
        int lat; int acks; logic b1, e, pe, a2; logic [31:0] rd;
        access(1'b1, 16'h0020, 32'h11112222, 1'b0, lat, b1, e, pe, a2, rd);
        @(negedge clk);
        bus.addr = 16'h0020; bus.wr_data = 32'h55AA55AA; bus.wr_en = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL abort_busy: got %b want 1", bus.busy); end
        reset = 1'b1; bus.wr_en = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.ack !== 1'b0) begin n_bad++; $display("FAIL abort_ack: got %b want 0", bus.ack); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy_clr: got %b want 0", bus.busy); end
        n_cmp++; if (bus.rd_data !== 32'h0) begin n_bad++; $display("FAIL abort_rd_data: got %h want 0", bus.rd_data); end
        n_cmp++; if (dbg_state !== 2'd0) begin n_bad++; $display("FAIL abort_state: got %0d want 0", dbg_state); end
        reset = 1'b0; acks = 0;
        repeat (5) begin @(negedge clk); acks += int'(bus.ack); end
        n_cmp++; if (acks !== 0) begin n_bad++; $display("FAIL abort_late_ack: got %0d want 0", acks); end
        access(1'b0, 16'h0020, 32'h0, 1'b0, lat, b1, e, pe, a2, rd);
        n_cmp++; if (rd !== 32'h11112222) begin n_bad++; $display("FAIL abort_mem_kept: got %h want 11112222", rd); end
    endtask

    task automatic test_back_to_back();
        int lat; logic b1, e, pe, a2; logic [31:0] rd;
        access(1'b1, 16'h0040, 32'hA5A50001, 1'b0, lat, b1, e, pe, a2, rd);
        access(1'b0, 16'h0040, 32'h0, 1'b0, lat, b1, e, pe, a2, rd);
        n_cmp++; if (rd !== 32'hA5A50001) begin n_bad++; $display("FAIL b2b_first: got %h want a5a50001", rd); end
        access(1'b1, 16'h0040, 32'h0F0F0F0F, 1'b0, lat, b1, e, pe, a2, rd);
        access(1'b0, 16'h0040, 32'h0, 1'b0, lat, b1, e, pe, a2, rd);
        n_cmp++; if (rd !== 32'h0F0F0F0F) begin n_bad++; $display("FAIL b2b_second: got %h want 0f0f0f0f", rd); end
        access(1'b0, 16'h00FF, 32'h0, 1'b0, lat, b1, e, pe, a2, rd);
        n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL top_word_err: got %b want 0", e); end
    endtask

`ifdef MEM_RESP_PARITY_EN
    task automatic test_parity();
        int lat; logic b1, e, pe, a2; logic [31:0] rd;
        access(1'b1, 16'h0030, 32'h00000001, 1'b1, lat, b1, e, pe, a2, rd);
        access(1'b0, 16'h0030, 32'h0, 1'b0, lat, b1, e, pe, a2, rd);
        n_cmp++; if (rd !== 32'h1) begin n_bad++; $display("FAIL par_inj_data: got %h want 1", rd); end
        n_cmp++; if (pe !== 1'b1) begin n_bad++; $display("FAIL par_inj_err: got %b want 1", pe); end
        n_cmp++; if (bus.parity_err !== 1'b0) begin n_bad++; $display("FAIL par_err_width: got %b want 0", bus.parity_err); end
        access(1'b1, 16'h0030, 32'h00000001, 1'b0, lat, b1, e, pe, a2, rd);
        access(1'b0, 16'h0030, 32'h0, 1'b0, lat, b1, e, pe, a2, rd);
        n_cmp++; if (pe !== 1'b0) begin n_bad++; $display("FAIL par_clean_err: got %b want 0", pe); end
        n_cmp++; if (rd !== 32'h1) begin n_bad++; $display("FAIL par_clean_data: got %h want 1", rd); end
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_held_enable();
        test_conflict();
        test_out_of_range();
        test_reset_abort();
        test_back_to_back();
`ifdef MEM_RESP_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
